// File: rtl/bayer_pkg.sv
// Shared CFA constants, site classes, FSM states and rounding averages
// for the 3x3 bilinear Bayer demosaic.
package bayer_pkg;

    localparam logic [1:0] PAT_RGGB = 2'd0;
    localparam logic [1:0] PAT_GRBG = 2'd1;
    localparam logic [1:0] PAT_GBRG = 2'd2;
    localparam logic [1:0] PAT_BGGR = 2'd3;

    localparam int ROW_W = 16;
    localparam int ACC_W = 16;

    typedef enum logic [1:0] {
        SITE_R,
        SITE_GR,
        SITE_GB,
        SITE_B
    } site_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    function automatic logic [ACC_W-1:0] avg2(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b
    );
        return (a + b + ACC_W'(1)) >> 1;
    endfunction

    function automatic logic [ACC_W-1:0] avg4(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b,
        input logic [ACC_W-1:0] c,
        input logic [ACC_W-1:0] d
    );
        return (a + b + c + d + ACC_W'(2)) >> 2;
    endfunction

    // (py,px) is the centre parity folded with the CFA phase
    function automatic site_t site_of(
        input logic py,
        input logic px
    );
        site_t s;
        s = SITE_R;
        unique case ({py, px})
            2'b00: s = SITE_R;
            2'b01: s = SITE_GR;
            2'b10: s = SITE_GB;
            2'b11: s = SITE_B;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bayer_line_buffer.sv
// Two-line delay: on each write the column slot shifts row r-1 into r-2
// and stores the new sample; reads are combinational at the same column.
import bayer_pkg::*;

module bayer_line_buffer #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_data,
    output logic [PIX_W-1:0] o_row1,
    output logic [PIX_W-1:0] o_row2
);

    logic [PIX_W-1:0] r_mem1 [0:DEPTH-1];
    logic [PIX_W-1:0] r_mem2 [0:DEPTH-1];

    assign o_row1 = r_mem1[i_addr];
    assign o_row2 = r_mem2[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem1[i_addr] <= i_data;
            r_mem2[i_addr] <= r_mem1[i_addr];
        end
    end

endmodule

// File: rtl/bayer_demosaic_3x3.sv
// Bilinear 3x3 Bayer-to-RGB demosaic with valid/ready streaming,
// frame/line markers and a single registered output stage.
import bayer_pkg::*;

module bayer_demosaic_3x3 #(
    parameter int PIX_W     = 8,
    parameter int MAX_WIDTH = 640,
    parameter int COL_W     = $clog2(MAX_WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         cfg_pattern,
    input  logic [COL_W-1:0]   cfg_width,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [PIX_W-1:0]   s_data,
    input  logic               s_sof,
    input  logic               s_eol,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [3*PIX_W-1:0] m_data,
    output logic               m_sof,
    output logic               m_eol,
    output logic               err_line
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    state_t r_state;
    state_t w_state_nxt;

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_width;
    logic [1:0]       r_pat;
    logic             r_err;

    logic               r_m_valid;
    logic [3*PIX_W-1:0] r_m_data;
    logic               r_m_sof;
    logic               r_m_eol;

    logic [PIX_W-1:0] r_t1, r_m1, r_b1;
    logic [PIX_W-1:0] r_t2, r_m2, r_b2;

    logic             w_acc;
    logic             w_proc;
    logic             w_load;
    logic [COL_W-1:0] w_cur_col;
    logic [ROW_W-1:0] w_cur_row;
    logic [COL_W-1:0] w_width;
    logic             w_last;
    logic             w_line_end;
    logic             w_err_now;
    logic [PIX_W-1:0] w_lb_r1;
    logic [PIX_W-1:0] w_lb_r2;

    assign s_ready  = m_ready | ~r_m_valid;
    assign w_acc    = s_valid & s_ready;
    assign w_proc   = w_acc & (s_sof | (r_state == ST_ACTIVE));

    // An sof beat is always pixel (0,0) of a fresh frame
    assign w_cur_col  = s_sof ? '0 : r_col;
    assign w_cur_row  = s_sof ? '0 : r_row;
    assign w_width    = s_sof ? cfg_width : r_width;
    assign w_last     = (w_cur_col == w_width - COL_W'(1));
    assign w_line_end = s_eol | w_last;
    assign w_err_now  = s_eol ^ w_last;

    assign w_load = w_proc
                  & (w_cur_row >= ROW_W'(2))
                  & (w_cur_col >= COL_W'(2));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc & s_sof) begin
            w_state_nxt = ST_ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col   <= '0;
            r_row   <= '0;
            r_width <= COL_W'(MAX_WIDTH);
            r_pat   <= PAT_RGGB;
            r_err   <= 1'b0;
        end else begin
            if (w_acc & s_sof) begin
                r_width <= cfg_width;
                r_pat   <= cfg_pattern;
            end
            if (w_proc) begin
                r_col <= w_line_end ? '0 : w_cur_col + COL_W'(1);
                if (w_line_end && (w_cur_row != '1)) begin
                    r_row <= w_cur_row + ROW_W'(1);
                end else begin
                    r_row <= w_cur_row;
                end
                if (s_sof) begin
                    r_err <= w_err_now;
                end else if (w_err_now) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    bayer_line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (MAX_WIDTH),
        .AW    (AW)
    ) u_lbuf (
        .clk    (clk),
        .i_we   (w_proc),
        .i_addr (w_cur_col[AW-1:0]),
        .i_data (s_data),
        .o_row1 (w_lb_r1),
        .o_row2 (w_lb_r2)
    );

    always_ff @(posedge clk) begin
        if (w_proc) begin
            r_t1 <= w_lb_r2;
            r_m1 <= w_lb_r1;
            r_b1 <= s_data;
            r_t2 <= r_t1;
            r_m2 <= r_m1;
            r_b2 <= r_b1;
        end
    end

    logic [PIX_W-1:0] w_c, w_n, w_s, w_e, w_w;
    logic [PIX_W-1:0] w_nw, w_ne, w_sw, w_se;

    // Columns c-2, c-1, c map to W, centre, E; rows r-2, r-1, r to N, centre, S
    assign w_c  = r_m1;
    assign w_n  = r_t1;
    assign w_s  = r_b1;
    assign w_w  = r_m2;
    assign w_e  = w_lb_r1;
    assign w_nw = r_t2;
    assign w_ne = w_lb_r2;
    assign w_sw = r_b2;
    assign w_se = s_data;

    logic [PIX_W-1:0] w_x4, w_d4, w_h2, w_v2;

    assign w_x4 = PIX_W'(avg4(ACC_W'(w_n), ACC_W'(w_s),
                              ACC_W'(w_e), ACC_W'(w_w)));
    assign w_d4 = PIX_W'(avg4(ACC_W'(w_nw), ACC_W'(w_ne),
                              ACC_W'(w_sw), ACC_W'(w_se)));
    assign w_h2 = PIX_W'(avg2(ACC_W'(w_e), ACC_W'(w_w)));
    assign w_v2 = PIX_W'(avg2(ACC_W'(w_n), ACC_W'(w_s)));

    site_t            w_site;
    logic [3*PIX_W-1:0] w_rgb;

    // Centre is (row-1, col-1), so its parity is the inverse of the counters'
    assign w_site = site_of(~w_cur_row[0] ^ r_pat[1],
                            ~w_cur_col[0] ^ r_pat[0]);

    always_comb begin
        w_rgb = {w_c, w_c, w_c};
        unique case (w_site)
            SITE_R:  w_rgb = {w_c,  w_x4, w_d4};
            SITE_B:  w_rgb = {w_d4, w_x4, w_c};
            SITE_GR: w_rgb = {w_h2, w_c,  w_v2};
            SITE_GB: w_rgb = {w_v2, w_c,  w_h2};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_sof   <= 1'b0;
            r_m_eol   <= 1'b0;
        end else if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_rgb;
            r_m_sof   <= (w_cur_row == ROW_W'(2)) && (w_cur_col == COL_W'(2));
            r_m_eol   <= w_last;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_sof    = r_m_sof;
    assign m_eol    = r_m_eol;
    assign err_line = r_err;

endmodule

// File: tb/tb_bayer_demosaic_3x3.sv
// Directed bench for bayer_demosaic_3x3: an image-level bilinear model
// feeds an expected queue checked against every accepted output pixel.
module tb_bayer_demosaic_3x3;

    localparam int PW = 8;
    localparam int MW = 640;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    cfg_pattern;
    logic [CW-1:0] cfg_width;
    logic          s_valid;
    logic          s_ready;
    logic [PW-1:0] s_data;
    logic          s_sof;
    logic          s_eol;
    logic          m_valid;
    logic          m_ready;
    logic [3*PW-1:0] m_data;
    logic          m_sof;
    logic          m_eol;
    logic          err_line;

    always #5 clk = ~clk;

    bayer_demosaic_3x3 #(
        .PIX_W     (PW),
        .MAX_WIDTH (MW),
        .COL_W     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_pattern (cfg_pattern),
        .cfg_width   (cfg_width),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_sof       (s_sof),
        .s_eol       (s_eol),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_sof       (m_sof),
        .m_eol       (m_eol),
        .err_line    (err_line)
    );

    logic [7:0]  img [0:7][0:639];
    int          cur_w;
    logic [25:0] exp_q[$];
    logic [25:0] log_q[$];
    bit          chk_en  = 1'b1;
    bit          rnd_rdy = 1'b0;
    int          n_chk   = 0;
    int          n_pass  = 0;
    int          n_out   = 0;
    bit          prev_stall = 1'b0;
    logic [25:0] held;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Colour of the raw sample at (y,x): 0=R 1=G 2=B, from the 2x2 tile
    function automatic int colour_at(int y, int x, int pat);
        int t;
        t = (y % 2) * 2 + (x % 2);
        case (pat)
            0: return (t == 0) ? 0 : (t == 3) ? 2 : 1;
            1: return (t == 1) ? 0 : (t == 2) ? 2 : 1;
            2: return (t == 2) ? 0 : (t == 1) ? 2 : 1;
            default: return (t == 3) ? 0 : (t == 0) ? 2 : 1;
        endcase
    endfunction

    function automatic logic [25:0] model_pix(int y, int x, int pat);
        int c, n, s, w, e, d, r, g, b, cls;
        logic [7:0] r8, g8, b8;
        c = img[y][x];
        n = img[y-1][x];
        s = img[y+1][x];
        w = img[y][x-1];
        e = img[y][x+1];
        d = img[y-1][x-1] + img[y-1][x+1] + img[y+1][x-1] + img[y+1][x+1];
        cls = colour_at(y, x, pat);
        if (cls == 0) begin
            r = c; g = (n + s + e + w + 2) / 4; b = (d + 2) / 4;
        end else if (cls == 2) begin
            b = c; g = (n + s + e + w + 2) / 4; r = (d + 2) / 4;
        end else if (colour_at(y, x + 1, pat) == 0) begin
            g = c; r = (e + w + 1) / 2; b = (n + s + 1) / 2;
        end else begin
            g = c; b = (e + w + 1) / 2; r = (n + s + 1) / 2;
        end
        r8 = r[7:0];
        g8 = g[7:0];
        b8 = b[7:0];
        return {r8, g8, b8, (y == 1 && x == 1), (x == cur_w - 2)};
    endfunction

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [25:0] cur, e;
        cur = {m_data, m_sof, m_eol};
        if (prev_stall && m_valid) chk("stall_hold", cur, held);
        prev_stall = m_valid && !m_ready && !reset;
        held = cur;
        if (m_valid && m_ready && !reset) begin
            n_out++;
            log_q.push_back(cur);
            if (chk_en) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: got %0h, expected none",
                             cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", cur, e);
                end
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input bit sof,
                             input bit eol, input bit gaps);
        int  k, t;
        bit  acc;
        if (gaps) begin
            k = $urandom_range(0, 2);
            s_valid = 1'b0;
            repeat (k) begin @(posedge clk); #1; end
        end
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        s_eol   = eol;
        t = 0;
        forever begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            t++;
            if (acc) break;
            if (t > 1000) begin
                n_chk++;
                $display("FAIL beat_timeout: got no accept, expected one");
                break;
            end
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(nm, exp_q.size(), 0);
        wait_cyc(2);
    endtask

    // cfg_* are scrambled right after the sof beat to show they are frozen
    task automatic run_frame(input int w, input int h, input int pat,
                             input int pat_mid, input bit gaps);
        cfg_width   = CW'(w);
        cfg_pattern = 2'(pat);
        cur_w       = w;
        for (int y = 1; y <= h - 2; y++)
            for (int x = 1; x <= w - 2; x++)
                exp_q.push_back(model_pix(y, x, pat));
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                send_beat(img[y][x], (y == 0 && x == 0), (x == w - 1), gaps);
                if (y == 0 && x == 0) begin
                    cfg_pattern = 2'(pat_mid);
                    cfg_width   = CW'(3);
                end
            end
        end
        drain("frame_drain");
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 640; x++) img[y][x] = v;
    endtask

    task automatic fill_ramp();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 640; x++) img[y][x] = 8'((16 * y + x) & 255);
    endtask

    task automatic fill_rand();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 640; x++) img[y][x] = 8'($urandom_range(0, 255));
    endtask

    task automatic fill_lit();
        img[0][0] = 8'd1;  img[0][1] = 8'd2;   img[0][2] = 8'd4;
        img[1][0] = 8'd8;  img[1][1] = 8'd100; img[1][2] = 8'd16;
        img[2][0] = 8'd32; img[2][1] = 8'd64;  img[2][2] = 8'd128;
    endtask

    initial begin
        int          n0;
        logic [25:0] e0;
        reset       = 1'b1;
        s_valid     = 1'b0;
        s_data      = '0;
        s_sof       = 1'b0;
        s_eol       = 1'b0;
        cfg_pattern = 2'd0;
        cfg_width   = CW'(4);
        cur_w       = 4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_markers", {m_sof, m_eol}, 0);
        chk("rst_err", err_line, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // constant grey frame
        fill_const(8'h80);
        log_q.delete();
        n0 = n_out;
        run_frame(4, 4, 0, 0, 0);
        chk("t1_count", n_out - n0, 4);
        e0 = log_q[0];
        chk("t1_data0", e0[25:2], 24'h808080);
        chk("t1_sof0", e0[1], 1);
        chk("t1_eol0", e0[0], 0);
        e0 = log_q[1];
        chk("t1_eol1", e0[0], 1);
        e0 = log_q[3];
        chk("t1_eol3", e0[0], 1);

        // single-output frames with hand-worked rounding
        fill_lit();
        log_q.delete();
        run_frame(3, 3, 0, 0, 0);
        chk("lit_rggb", log_q[0], {24'h291764, 2'b11});
        fill_lit();
        log_q.delete();
        run_frame(3, 3, 1, 1, 0);
        chk("lit_grbg", log_q[0], {24'h21640C, 2'b11});

        // all four phases, ramp and random content
        for (int p = 0; p < 4; p++) begin
            fill_ramp();
            n0 = n_out;
            run_frame(6, 6, p, p, 0);
            chk("t2_ramp_count", n_out - n0, 16);
            fill_rand();
            run_frame(6, 6, p, p, 0);
            chk("t2_err_clean", err_line, 0);
        end

        // full width, random backpressure and input gaps
        rnd_rdy = 1'b1;
        fill_rand();
        n0 = n_out;
        run_frame(640, 8, 1, 1, 1);
        chk("t3_count", n_out - n0, 638 * 6);
        rnd_rdy = 1'b0;
        wait_cyc(3);

        // short first line
        fill_rand();
        chk_en = 1'b0;
        log_q.delete();
        cfg_width   = CW'(5);
        cfg_pattern = 2'd0;
        cur_w       = 5;
        for (int x = 0; x < 3; x++) send_beat(img[0][x], x == 0, x == 2, 0);
        chk("t4_err_set", err_line, 1);
        for (int y = 1; y < 4; y++)
            for (int x = 0; x < 5; x++) send_beat(img[y][x], 0, x == 4, 0);
        wait_cyc(4);
        chk("t4_count", log_q.size(), 6);
        for (int x = 1; x <= 3; x++) chk("t4_aligned", log_q[2 + x], model_pix(2, x, 0));
        chk("t4_err_sticky", err_line, 1);
        chk_en = 1'b1;
        fill_const(8'h10);
        cfg_width = CW'(3);
        cur_w     = 3;
        exp_q.push_back(model_pix(1, 1, 0));
        send_beat(img[0][0], 1, 0, 0);
        chk("t4_err_clear", err_line, 0);
        for (int i = 1; i < 9; i++) send_beat(img[i / 3][i % 3], 0, (i % 3) == 2, 0);
        drain("t4_drain");

        // reset in the middle of a line
        fill_rand();
        chk_en = 1'b0;
        cfg_width   = CW'(6);
        cfg_pattern = 2'd0;
        for (int i = 0; i < 16; i++) send_beat(img[i / 6][i % 6], i == 0, (i % 6) == 5, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_m_valid", m_valid, 0);
        chk("t5_m_data", m_data, 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        log_q.delete();
        chk_en = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 20; i++) send_beat(img[i / 6][i % 6], 0, (i % 6) == 5, 0);
        wait_cyc(3);
        chk("t5_idle_quiet", n_out - n0, 0);
        fill_rand();
        n0 = n_out;
        run_frame(6, 6, 2, 2, 0);
        chk("t5_count", n_out - n0, 16);

        // phase register must ignore a mid-frame pattern change
        fill_rand();
        n0 = n_out;
        run_frame(6, 6, 0, 3, 0);
        chk("t6_count", n_out - n0, 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
